taus_multi: RTL and testbench

TAUS_MULTI -- requirements
Module: taus_multi

---
 rtl/taus_pkg.sv | 34 +++
 rtl/taus_lane.sv | 54 +++++
 rtl/taus_multi.sv | 131 +++++++++++++
 tb/tb_taus_multi.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/taus_pkg.sv
// Shared constants, FSM encoding and per-component step helpers for the
// multi-lane taus113 generator.
//   comp_step : one taus113 recurrence step for component c (0..3 = S1..S4)
//   fixup     : raises a freshly seeded component above its minimum
package taus_pkg;

  localparam logic [31:0] LcgMult   = 32'd69069;
  localparam logic [31:0] LaneConst = 32'h9E3779B9;

  // Index 0 is S1 / C1, index 3 is S4 / C4.
  localparam logic [3:0][31:0] CompMask = {32'hFFFFFF80, 32'hFFFFFFF0, 32'hFFFFFFF8, 32'hFFFFFFFE};
  localparam logic [3:0][4:0]  ShInner  = {5'd3, 5'd13, 5'd2, 5'd6};
  localparam logic [3:0][4:0]  ShRight  = {5'd12, 5'd21, 5'd27, 5'd13};
  localparam logic [3:0][4:0]  ShMask   = {5'd13, 5'd7, 5'd2, 5'd18};
  localparam logic [3:0][31:0] FixMin   = {32'd128, 32'd16, 32'd8, 32'd2};

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSeed   = 2'd1,
    StWarmup = 2'd2,
    StRun    = 2'd3
  } state_e;

  function automatic logic [31:0] comp_step(input logic [31:0] s, input logic [1:0] c);
    logic [31:0] b;
    b = ((s << ShInner[c]) ^ s) >> ShRight[c];
    return ((s & CompMask[c]) << ShMask[c]) ^ b;
  endfunction

  function automatic logic [31:0] fixup(input logic [31:0] v, input logic [1:0] c);
    return (v < FixMin[c]) ? v + FixMin[c] : v;
  endfunction

endpackage

// File: rtl/taus_lane.sv
// One taus113 lane: LCG seeding register, four state components, fixup and
// the combined-Tausworthe step.
//   clk, rst_n     : clock, synchronous active-low reset
//   load, load_val : load the LCG with this lane's derived seed
//   seed_wr        : advance the LCG and write component seed_idx
//   seed_idx       : component being seeded (0..3 = S1..S4)
//   step           : advance all four components one taus113 step
//   rnd            : S1 ^ S2 ^ S3 ^ S4 of the current state
module taus_lane
  import taus_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        seed_wr,
  input  logic [1:0]  seed_idx,
  input  logic        step,
  output logic [31:0] rnd
);

  logic [3:0][31:0] s_q, s_d;
  logic [31:0]      lcg_q, lcg_d, lcg_next;

  assign lcg_next = lcg_q * LcgMult;

  always_comb begin
    s_d   = s_q;
    lcg_d = lcg_q;
    if (load) begin
      lcg_d = load_val;
    end else if (seed_wr) begin
      lcg_d         = lcg_next;
      s_d[seed_idx] = fixup(lcg_next, seed_idx);
    end else if (step) begin
      for (int c = 0; c < 4; c++) begin
        s_d[c] = comp_step(s_q[c], 2'(c));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= '0;
      lcg_q <= '0;
    end else begin
      s_q   <= s_d;
      lcg_q <= lcg_d;
    end
  end

  assign rnd = s_q[0] ^ s_q[1] ^ s_q[2] ^ s_q[3];

endmodule

// File: rtl/taus_multi.sv
// N_LANES independent taus113 generators seeded from one master seed, with a
// shared IDLE/SEED/WARMUP/RUN controller and a valid/ready output handshake.
//   clk, rst_n            : clock, synchronous active-low reset
//   seed, seed_valid      : master seed offer
//   seed_ready            : seed accepted this cycle when high (IDLE or RUN)
//   rnd                   : lane i word on bits [32i+31:32i]
//   rnd_valid, rnd_ready  : output handshake; lanes step on each handshake
//   busy                  : seeding or warming up
//   delivered_cnt         : saturating handshake count (only with TAUS_MULTI_STATS_EN)
module taus_multi
  import taus_pkg::*;
#(
  parameter int unsigned N_LANES       = 4,
  parameter int unsigned WARMUP_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            seed,
  input  logic                   seed_valid,
  output logic                   seed_ready,
  output logic [32*N_LANES-1:0]  rnd,
  output logic                   rnd_valid,
  input  logic                   rnd_ready,
  output logic                   busy
`ifdef TAUS_MULTI_STATS_EN
  ,
  output logic [31:0]            delivered_cnt
`endif
);

  // Last warm-up count value; unused when WARMUP_CYCLES is 0.
  localparam logic [7:0] WarmLast = 8'(WARMUP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] warm_q, warm_d;
  logic [1:0] kcnt_q, kcnt_d;
  logic       accept, load, seed_wr, step;

  assign seed_ready = (state_q == StIdle) || (state_q == StRun);
  assign accept     = seed_valid && seed_ready;
  assign rnd_valid  = (state_q == StRun);
  assign busy       = (state_q == StSeed) || (state_q == StWarmup);

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    kcnt_d  = kcnt_q;
    load    = 1'b0;
    seed_wr = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load    = 1'b1;
          kcnt_d  = 2'd0;
          state_d = StSeed;
        end
      end
      StSeed: begin
        seed_wr = 1'b1;
        kcnt_d  = kcnt_q + 2'd1;
        if (kcnt_q == 2'd3) begin
          warm_d  = 8'd0;
          state_d = (WARMUP_CYCLES == 0) ? StRun : StWarmup;
        end
      end
      StWarmup: begin
        step   = 1'b1;
        warm_d = warm_q + 8'd1;
        if (warm_q == WarmLast) begin
          warm_d  = 8'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        // A reseed wins over a simultaneous handshake; that word is dropped.
        if (accept) begin
          load    = 1'b1;
          kcnt_d  = 2'd0;
          state_d = StSeed;
        end else if (rnd_ready) begin
          step = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      warm_q  <= '0;
      kcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      kcnt_q  <= kcnt_d;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    logic [31:0] lane_seed;
    assign lane_seed = seed ^ (32'(i) * LaneConst);

    taus_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (lane_seed),
      .seed_wr  (seed_wr),
      .seed_idx (kcnt_q),
      .step     (step),
      .rnd      (rnd[32*i +: 32])
    );
  end

`ifdef TAUS_MULTI_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || accept) begin
      cnt_q <= '0;
    end else if (rnd_valid && rnd_ready && (cnt_q != 32'hFFFFFFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign delivered_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_taus_multi.sv
// Randomized bench for taus_multi against a transaction-level taus113 model.
module tb_taus_multi;

  localparam int NL = 4;
  localparam int W  = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [31:0]     seed = '0;
  logic            seed_valid = 1'b0;
  logic            seed_ready;
  logic [32*NL-1:0] rnd;
  logic            rnd_valid;
  logic            rnd_ready = 1'b0;
  logic            busy;

  logic [31:0]     seed_b = '0;
  logic            seed_valid_b = 1'b0;
  logic            seed_ready_b;
  logic [31:0]     rnd_b;
  logic            rnd_valid_b;
  logic            busy_b;

`ifdef TAUS_MULTI_STATS_EN
  logic [31:0]     delivered_cnt;
  logic [31:0]     delivered_cnt_b;
`endif

  always #5 clk = ~clk;

  taus_multi #(.N_LANES(NL), .WARMUP_CYCLES(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed       (seed),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .busy       (busy)
`ifdef TAUS_MULTI_STATS_EN
    ,
    .delivered_cnt (delivered_cnt)
`endif
  );

  taus_multi #(.N_LANES(1), .WARMUP_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed       (seed_b),
    .seed_valid (seed_valid_b),
    .seed_ready (seed_ready_b),
    .rnd        (rnd_b),
    .rnd_valid  (rnd_valid_b),
    .rnd_ready  (1'b0),
    .busy       (busy_b)
`ifdef TAUS_MULTI_STATS_EN
    ,
    .delivered_cnt (delivered_cnt_b)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] tstep(input logic [127:0] st);
    logic [31:0] s1, s2, s3, s4;
    s1 = st[31:0]; s2 = st[63:32]; s3 = st[95:64]; s4 = st[127:96];
    s1 = ((s1 & 32'hFFFFFFFE) << 18) ^ (((s1 << 6) ^ s1) >> 13);
    s2 = ((s2 & 32'hFFFFFFF8) << 2) ^ (((s2 << 2) ^ s2) >> 27);
    s3 = ((s3 & 32'hFFFFFFF0) << 7) ^ (((s3 << 13) ^ s3) >> 21);
    s4 = ((s4 & 32'hFFFFFF80) << 13) ^ (((s4 << 3) ^ s4) >> 12);
    return {s4, s3, s2, s1};
  endfunction

  function automatic logic [127:0] seed_lane(input logic [31:0] sd, input int lane, input int warm);
    logic [31:0] x;
    logic [31:0] s [4];
    logic [31:0] mins [4];
    logic [127:0] st;
    mins = '{32'd2, 32'd8, 32'd16, 32'd128};
    x = sd ^ (32'(lane) * 32'h9E3779B9);
    for (int k = 0; k < 4; k++) begin
      x = x * 32'd69069;
      s[k] = (x < mins[k]) ? x + mins[k] : x;
    end
    st = {s[3], s[2], s[1], s[0]};
    for (int w = 0; w < warm; w++) st = tstep(st);
    return st;
  endfunction

  function automatic logic [31:0] word(input logic [127:0] st);
    return st[31:0] ^ st[63:32] ^ st[95:64] ^ st[127:96];
  endfunction

  logic         m_on = 1'b0;
  logic         m_valid, m_zero;
  int           m_wait;
  logic [31:0]  m_cnt;
  logic [127:0] m_s [NL];

  // Cycles until valid are counted down from the accepting edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_on    <= 1'b1;
      m_valid <= 1'b0;
      m_zero  <= 1'b1;
      m_wait  <= 0;
      m_cnt   <= '0;
      for (int i = 0; i < NL; i++) m_s[i] <= '0;
    end else if (m_on) begin
      if (seed_valid && m_wait == 0) begin
        for (int i = 0; i < NL; i++) m_s[i] <= seed_lane(seed, i, W);
        m_valid <= 1'b0;
        m_zero  <= 1'b0;
        m_wait  <= 4 + W;
        m_cnt   <= '0;
      end else if (m_wait != 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) m_valid <= 1'b1;
      end else if (m_valid && rnd_ready) begin
        for (int i = 0; i < NL; i++) m_s[i] <= tstep(m_s[i]);
        if (m_cnt != 32'hFFFFFFFF) m_cnt <= m_cnt + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("rnd_valid", 32'(rnd_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_wait != 0));
      chk("seed_ready", 32'(seed_ready), 32'(m_wait == 0));
      if (m_valid || m_zero)
        for (int i = 0; i < NL; i++) chk("rnd_lane", rnd[32*i +: 32], word(m_s[i]));
`ifdef TAUS_MULTI_STATS_EN
      chk("delivered_cnt", delivered_cnt, m_cnt);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_seed(input logic [31:0] s);
    seed = s;
    seed_valid = 1'b1;
    tick();
    seed_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    int hs;
    int budget;

    // Pin the model: seed 0, no warm-up gives {2,8,16,128} -> 0x9A.
    chk("model_seed0", word(seed_lane(32'd0, 0, 0)), 32'h0000009A);

    rst_n = 1'b0;
    tick(); tick();
    chk("reset_rnd", rnd[31:0], 32'h0);
    chk("reset_seed_ready", 32'(seed_ready), 32'h1);
    rst_n = 1'b1;
    tick();

    // Single lane, no warm-up, seed 0.
    seed_b = 32'd0;
    seed_valid_b = 1'b1;
    tick();
    seed_valid_b = 1'b0;
    tick(); tick(); tick();
    chk("b_valid_T4", 32'(rnd_valid_b), 32'h0);
    tick();
    chk("b_valid_T5", 32'(rnd_valid_b), 32'h1);
    chk("b_rnd_T5", rnd_b, 32'h0000009A);
    chk("b_busy_T5", 32'(busy_b), 32'h0);

    // Seed 12345: valid exactly at T+15; extra seed offers during SEED ignored.
    accept_seed(32'd12345);
    seed = 32'hDEADBEEF;
    seed_valid = 1'b1;
    chk("seed_ready_in_seed", 32'(seed_ready), 32'h0);
    tick(); tick(); tick();
    seed_valid = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    chk("valid_T14", 32'(rnd_valid), 32'h0);
    tick();
    chk("valid_T15", 32'(rnd_valid), 32'h1);

    // 1000 handshakes with random back-pressure.
    hs = 0;
    budget = 0;
    while (hs < 1000 && budget < 6000) begin
      rnd_ready = ($urandom_range(0, 3) != 0);
      if (rnd_valid && rnd_ready) hs++;
      tick();
      budget++;
    end
    chk("handshakes_done", 32'(hs), 32'd1000);

    // Hold off the consumer: output must freeze.
    rnd_ready = 1'b0;
    held = rnd[63:32];
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("hold_stable", rnd[63:32], held);
    end
    rnd_ready = 1'b1;
    tick(); tick();

`ifdef TAUS_MULTI_STATS_EN
    accept_seed(32'hA5A5_0001);
    rnd_ready = 1'b0;
    for (int c = 0; c < 15; c++) tick();
    rnd_ready = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    rnd_ready = 1'b0;
    chk("stats_seven", delivered_cnt, 32'd7);
    accept_seed(32'h1234_5678);
    chk("stats_cleared", delivered_cnt, 32'd0);
    for (int c = 0; c < 15; c++) tick();
`endif

    // Reseed in RUN with a simultaneous handshake.
    rnd_ready = 1'b1;
    chk("run_before_reseed", 32'(rnd_valid), 32'h1);
    accept_seed(32'hCAFEF00D);
    chk("reseed_valid_drop", 32'(rnd_valid), 32'h0);
    for (int c = 0; c < 40; c++) tick();

    // Reset in the middle of warm-up.
    accept_seed(32'h0BAD_5EED);
    for (int c = 0; c < 7; c++) tick();
    chk("busy_in_warmup", 32'(busy), 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_warm_valid", 32'(rnd_valid), 32'h0);
    chk("rst_warm_rnd", rnd[31:0], 32'h0);
    chk("rst_warm_busy", 32'(busy), 32'h0);
    for (int c = 0; c < 5; c++) tick();

    // Random reseeds and back-pressure.
    for (int c = 0; c < 600; c++) begin
      seed = $urandom;
      seed_valid = ($urandom_range(0, 29) == 0);
      rnd_ready = $urandom_range(0, 1) != 0;
      tick();
    end
    seed_valid = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
